// File: rtl/multicycle_controller.sv
// Control FSM for a shared-memory multicycle RISC-V datapath (R, I-ALU, LW, SW)
// with memory ready handshake, illegal-opcode trap and retired-instruction counter.
module multicycle_controller #(
    parameter int unsigned CNT_W = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [6:0]       Opcode,
    input  logic             mem_ready,
    output logic             PCWrite,
    output logic             IRWrite,
    output logic             IorD,
    output logic             ALUSrcA,
    output logic [1:0]       ALUSrcB,
    output logic [1:0]       ALUOp,
    output logic             RegWrite,
    output logic             MemRead,
    output logic             MemWrite,
    output logic             MemtoReg,
    output logic             illegal,
    output logic             retire,
    output logic [CNT_W-1:0] instr_count,
    output logic [3:0]       state_out
);

    typedef enum logic [3:0] {
        FETCH    = 4'd0,
        DECODE   = 4'd1,
        EXEC_R   = 4'd2,
        EXEC_I   = 4'd3,
        MEM_ADDR = 4'd4,
        MEM_RD   = 4'd5,
        MEM_WR   = 4'd6,
        WB_ALU   = 4'd7,
        WB_MEM   = 4'd8,
        TRAP     = 4'd9
    } state_t;

    localparam logic [6:0] OP_R  = 7'b0110011;
    localparam logic [6:0] OP_I  = 7'b0010011;
    localparam logic [6:0] OP_LW = 7'b0000011;
    localparam logic [6:0] OP_SW = 7'b0100011;

    state_t             state;
    state_t             next_state;
    logic [CNT_W-1:0]   count_q;

    always_ff @(posedge clk) begin
        if (reset) begin
            state <= FETCH;
        end else begin
            state <= next_state;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            count_q <= '0;
        end else if (retire) begin
            count_q <= count_q + CNT_W'(1);
        end
    end

    always_comb begin
        next_state = state;
        PCWrite    = 1'b0;
        IRWrite    = 1'b0;
        IorD       = 1'b0;
        ALUSrcA    = 1'b0;
        ALUSrcB    = 2'b00;
        ALUOp      = 2'b00;
        RegWrite   = 1'b0;
        MemRead    = 1'b0;
        MemWrite   = 1'b0;
        MemtoReg   = 1'b0;
        illegal    = 1'b0;
        retire     = 1'b0;
        case (state)
            FETCH: begin
                MemRead = 1'b1;
                ALUSrcB = 2'b01;
                ALUOp   = 2'b01;
                PCWrite = mem_ready;
                IRWrite = mem_ready;
                if (mem_ready) begin
                    next_state = DECODE;
                end
            end
            DECODE: begin
                case (Opcode)
                    OP_R:         next_state = EXEC_R;
                    OP_I:         next_state = EXEC_I;
                    OP_LW, OP_SW: next_state = MEM_ADDR;
                    default:      next_state = TRAP;
                endcase
            end
            EXEC_R: begin
                ALUSrcA    = 1'b1;
                ALUSrcB    = 2'b00;
                ALUOp      = 2'b10;
                next_state = WB_ALU;
            end
            EXEC_I: begin
                ALUSrcA    = 1'b1;
                ALUSrcB    = 2'b10;
                ALUOp      = 2'b00;
                next_state = WB_ALU;
            end
            MEM_ADDR: begin
                ALUSrcA = 1'b1;
                ALUSrcB = 2'b10;
                ALUOp   = 2'b01;
                // Only LW/SW reach here, so anything other than LW is a store.
                next_state = (Opcode == OP_LW) ? MEM_RD : MEM_WR;
            end
            MEM_RD: begin
                MemRead = 1'b1;
                IorD    = 1'b1;
                if (mem_ready) begin
                    next_state = WB_MEM;
                end
            end
            MEM_WR: begin
                MemWrite = 1'b1;
                IorD     = 1'b1;
                if (mem_ready) begin
                    retire     = 1'b1;
                    next_state = FETCH;
                end
            end
            WB_ALU: begin
                RegWrite   = 1'b1;
                retire     = 1'b1;
                next_state = FETCH;
            end
            WB_MEM: begin
                RegWrite   = 1'b1;
                MemtoReg   = 1'b1;
                retire     = 1'b1;
                next_state = FETCH;
            end
            TRAP: begin
                illegal = 1'b1;
            end
            default: begin
                next_state = FETCH;
            end
        endcase
    end

    assign instr_count = count_q;
    assign state_out   = state;

endmodule
